// File: rtl/bitvault_regfile_if.sv
// Bus bundle for bitvault_regfile: shared-address write port and combinational read port.
interface bitvault_regfile_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 2
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;

    modport master (
        output we,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  we,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/bitvault_regfile.sv
// DEPTH x WIDTH register file: synchronous write, asynchronous read, async active-high clear.
module bitvault_regfile #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input logic               clk,
    input logic               rst,
    bitvault_regfile_if.slave bus
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd_data;

    // Address compare per entry, so out-of-range addresses neither write nor read anything.
    always_comb begin
        mem_d = mem_q;
        if (bus.we) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (bus.addr == ADDR_W'(i)) begin
                    mem_d[i] = bus.data_in;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (bus.addr == ADDR_W'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

    assign bus.data_out = rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_bitvault_regfile.sv
// Directed, table-driven bench for bitvault_regfile (4 x 8 default configuration).
module tb_bitvault_regfile;

    logic clk;
    logic rst;

    bitvault_regfile_if #(.WIDTH(8), .ADDR_W(2)) bus ();

    bitvault_regfile #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] din;
        logic [7:0] exp_before;
        logic [7:0] exp_after;
    } vec_t;

    vec_t vecs [10];
    int   tests;
    int   failed;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic read_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp [4];
        exp = '{e0, e1, e2, e3};
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            #1;
            check($sformatf("%s_addr%0d", tag, a), bus.data_out, exp[a]);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        vecs[0] = '{1'b1, 2'd0, 8'hAA, 8'h00, 8'hAA};
        vecs[1] = '{1'b1, 2'd1, 8'h55, 8'h00, 8'h55};
        vecs[2] = '{1'b1, 2'd2, 8'hF0, 8'h00, 8'hF0};
        vecs[3] = '{1'b1, 2'd3, 8'h0F, 8'h00, 8'h0F};
        vecs[4] = '{1'b0, 2'd1, 8'h99, 8'h55, 8'h55};  // write protect
        vecs[5] = '{1'b1, 2'd1, 8'h99, 8'h55, 8'h99};
        vecs[6] = '{1'b1, 2'd2, 8'h3C, 8'hF0, 8'h3C};  // read during write, no bypass
        vecs[7] = '{1'b1, 2'd3, 8'h11, 8'h0F, 8'h11};
        vecs[8] = '{1'b1, 2'd3, 8'h22, 8'h11, 8'h22};  // back-to-back, last wins
        vecs[9] = '{1'b0, 2'd0, 8'hFF, 8'hAA, 8'hAA};

        rst         = 1'b0;
        bus.we      = 1'b0;
        bus.addr    = 2'd0;
        bus.data_in = 8'h00;
        #2 rst = 1'b1;
        #1;
        read_all("por", 8'h00, 8'h00, 8'h00, 8'h00);
        // Deassert between edges; no clock needed for release.
        #3 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.we      = vecs[i].we;
            bus.addr    = vecs[i].addr;
            bus.data_in = vecs[i].din;
            #1;
            check($sformatf("vec%0d_before", i), bus.data_out, vecs[i].exp_before);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_after", i), bus.data_out, vecs[i].exp_after);
        end

        @(negedge clk);
        bus.we = 1'b0;
        read_all("loaded", 8'hAA, 8'h99, 8'h3C, 8'h22);

        // Asynchronous clear mid-cycle: contents vanish without any clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        read_all("midrst", 8'h00, 8'h00, 8'h00, 8'h00);

        // Write attempted across an edge while reset is held.
        @(negedge clk);
        bus.we      = 1'b1;
        bus.addr    = 2'd3;
        bus.data_in = 8'h77;
        @(posedge clk);
        #1;
        check("rst_during_write", bus.data_out, 8'h00);

        @(negedge clk);
        bus.we = 1'b0;
        #2 rst = 1'b0;
        #1;
        read_all("postrst", 8'h00, 8'h00, 8'h00, 8'h00);

        // First edge after release accepts a write.
        @(negedge clk);
        bus.we      = 1'b1;
        bus.addr    = 2'd0;
        bus.data_in = 8'h5A;
        @(posedge clk);
        #1;
        check("first_write_after_rst", bus.data_out, 8'h5A);
        @(negedge clk);
        bus.we = 1'b0;
        read_all("final", 8'h5A, 8'h00, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
